// File: rtl/dcache_ctrl.sv
// dcache_ctrl: control FSM for the direct-mapped data cache.
// Runs read-miss block refills and write-through stores against data
// memory over a ready handshake, and keeps saturating read hit/miss counters.
module dcache_ctrl #(
    parameter int TAG_W = 3,
    parameter int IDX_W = 5,
    parameter int OFF_W = 2,
    parameter int CNT_W = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cpu_rd,
    input  logic                           cpu_wr,
    input  logic [TAG_W+IDX_W+OFF_W-1:0]   cpu_addr,
    input  logic                           valid_in,
    input  logic [TAG_W-1:0]               tag_in,
    input  logic                           mem_ready,
    output logic                           stall,
    output logic                           cache_read,
    output logic                           fill_from_Dmem,
    output logic                           fill_from_DataIn,
    output logic                           mem_rd,
    output logic                           mem_wr,
    output logic [TAG_W+IDX_W+OFF_W-1:0]   mem_addr,
    output logic [CNT_W-1:0]               hit_cnt,
    output logic [CNT_W-1:0]               miss_cnt
);
    localparam int ADDR_W = TAG_W + IDX_W + OFF_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_FILL,
        S_WR_WAIT,
        S_WR_DONE
    } state_t;

    state_t              r_state;
    logic                r_from_fill;   // previous cycle was FILL: next IDLE hit is the replay
    logic                r_mem_rd;
    logic                r_mem_wr;
    logic                r_fill_dmem;
    logic                r_fill_din;    // carries the latched write-hit flag for the first WR_WAIT cycle
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [CNT_W-1:0]    r_hit_cnt;
    logic [CNT_W-1:0]    r_miss_cnt;

    logic                w_hit;
    logic                w_wr_req;
    logic                w_rd_req;
    logic [ADDR_W-1:0]   w_blk_addr;

    // A simultaneous read and write is treated as a write.
    assign w_hit      = valid_in && (tag_in == cpu_addr[ADDR_W-1 -: TAG_W]);
    assign w_wr_req   = cpu_wr;
    assign w_rd_req   = cpu_rd && !cpu_wr;
    assign w_blk_addr = {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Stall and cache_read: combinational in IDLE so a read hit costs no cycle.
    always_comb begin
        stall      = 1'b1;
        cache_read = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall      = w_wr_req || (w_rd_req && !w_hit);
                cache_read = w_rd_req && w_hit;
            end
            S_WR_DONE: stall = 1'b0;
            default:   stall = 1'b1;
        endcase
    end

    // Controller FSM with registered memory/fill outputs and saturating counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_from_fill <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_fill_dmem <= 1'b0;
            r_fill_din  <= 1'b0;
            r_mem_addr  <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_from_fill <= (r_state == S_FILL);
            case (r_state)
                S_IDLE: begin
                    if (w_wr_req) begin
                        r_state    <= S_WR_WAIT;
                        r_mem_wr   <= 1'b1;
                        r_mem_addr <= cpu_addr;
                        r_fill_din <= w_hit;   // write miss is no-allocate
                    end else if (w_rd_req && !w_hit) begin
                        r_state    <= S_RD_WAIT;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= w_blk_addr;
                        if (r_miss_cnt != {CNT_W{1'b1}})
                            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                    end else if (w_rd_req) begin
                        // The replayed read right after a refill is not a first-attempt hit.
                        if (!r_from_fill && (r_hit_cnt != {CNT_W{1'b1}}))
                            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                    end
                end
                S_RD_WAIT: begin
                    if (mem_ready) begin
                        r_state     <= S_FILL;
                        r_mem_rd    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_fill_dmem <= 1'b1;
                    end
                end
                S_FILL: begin
                    r_state     <= S_IDLE;
                    r_fill_dmem <= 1'b0;
                end
                S_WR_WAIT: begin
                    r_fill_din <= 1'b0;
                    if (mem_ready) begin
                        r_state    <= S_WR_DONE;
                        r_mem_wr   <= 1'b0;
                        r_mem_addr <= '0;
                    end
                end
                S_WR_DONE: r_state <= S_IDLE;
                default: begin
                    r_state     <= S_IDLE;
                    r_mem_rd    <= 1'b0;
                    r_mem_wr    <= 1'b0;
                    r_fill_dmem <= 1'b0;
                    r_fill_din  <= 1'b0;
                end
            endcase
        end
    end

    assign fill_from_Dmem   = r_fill_dmem;
    assign fill_from_DataIn = r_fill_din;
    assign mem_rd           = r_mem_rd;
    assign mem_wr           = r_mem_wr;
    assign mem_addr         = r_mem_addr;
    assign hit_cnt          = r_hit_cnt;
    assign miss_cnt         = r_miss_cnt;

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: transaction-level checks of the data cache controller.
// The bench owns a model of the cache tag/valid array and a memory that
// answers after a chosen number of request cycles.
module tb_dcache_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd, cpu_wr, mem_ready;
    logic [9:0]  cpu_addr;
    logic        valid_in;
    logic [2:0]  tag_in;
    logic        stall, cache_read, fill_from_Dmem, fill_from_DataIn, mem_rd, mem_wr;
    logic [9:0]  mem_addr;
    logic [15:0] hit_cnt, miss_cnt;
    logic        stall2, cache_read2, fdm2, fdi2, mem_rd2, mem_wr2;
    logic [9:0]  mem_addr2;
    logic [1:0]  hit_cnt2, miss_cnt2;

    logic [31:0] mvalid;
    logic [2:0]  mtag [32];
    int          mhits, mmiss;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    assign valid_in = mvalid[cpu_addr[6:2]];
    assign tag_in   = mtag[cpu_addr[6:2]];

    dcache_ctrl dut (
        .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .valid_in(valid_in), .tag_in(tag_in), .mem_ready(mem_ready),
        .stall(stall), .cache_read(cache_read), .fill_from_Dmem(fill_from_Dmem),
        .fill_from_DataIn(fill_from_DataIn), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    dcache_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .valid_in(valid_in), .tag_in(tag_in), .mem_ready(mem_ready),
        .stall(stall2), .cache_read(cache_read2), .fill_from_Dmem(fdm2),
        .fill_from_DataIn(fdi2), .mem_rd(mem_rd2), .mem_wr(mem_wr2),
        .mem_addr(mem_addr2), .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2)
    );

    // One CPU operation from request to retirement, checked against the
    // cycle budget each kind of access is allowed.
    task automatic do_op(input logic rd, input logic wr, input logic [9:0] addr,
                         input int dly, input string nm);
        bit h   = mvalid[addr[6:2]] && (mtag[addr[6:2]] == addr[9:7]);
        int n_stall = 0, n_mrd = 0, n_mwr = 0, n_fd = 0, n_fdi = 0, n_bad = 0;
        int cyc = 0, wcnt = 0;
        int e_stall = 0, e_mrd = 0, e_mwr = 0, e_fd = 0, e_fdi = 0;
        int e_hit, e_miss, e_hit2, e_miss2;
        bit done = 0;
        logic cr_ret = 1'b0, e_cr = 1'b0;
        if (wr) begin
            e_stall = 1 + dly; e_mwr = dly; e_fdi = h ? 1 : 0;
        end else if (rd && h) begin
            e_cr = 1'b1; mhits++;
        end else if (rd) begin
            e_stall = 2 + dly; e_mrd = dly; e_fd = 1; e_cr = 1'b1; mmiss++;
        end
        cpu_rd = rd; cpu_wr = wr; cpu_addr = addr;
        while (!done) begin
            #1;
            if (stall) n_stall++;
            if (mem_rd) begin
                n_mrd++;
                if (mem_addr !== {addr[9:2], 2'b00}) n_bad++;
            end
            if (mem_wr) begin
                n_mwr++;
                if (mem_addr !== addr) n_bad++;
            end
            if (fill_from_Dmem) begin
                n_fd++;
                mvalid[addr[6:2]] = 1'b1;
                mtag[addr[6:2]]   = addr[9:7];
            end
            if (fill_from_DataIn) n_fdi++;
            if (mem_rd || mem_wr) begin
                wcnt++;
                mem_ready = (wcnt >= dly);
            end else begin
                mem_ready = 1'($urandom_range(0, 1));   // ignored outside the wait states
            end
            if (!stall) begin
                done = 1;
                cr_ret = cache_read;
            end
            cyc++;
            if (cyc > 60 && !done) begin
                checks++; failures++;
                $display("FAIL %s timeout stall still high after %0d cycles", nm, cyc);
                done = 1;
            end
            @(negedge clk);
        end
        cpu_rd = 1'b0; cpu_wr = 1'b0; mem_ready = 1'b0;
        #1;
        e_hit   = (mhits > 65535) ? 65535 : mhits;
        e_miss  = (mmiss > 65535) ? 65535 : mmiss;
        e_hit2  = (mhits > 3) ? 3 : mhits;
        e_miss2 = (mmiss > 3) ? 3 : mmiss;
        checks++; if (n_stall !== e_stall) begin failures++; $display("FAIL %s stall_cycles got=%0d exp=%0d", nm, n_stall, e_stall); end
        checks++; if (n_mrd !== e_mrd) begin failures++; $display("FAIL %s mem_rd_cycles got=%0d exp=%0d", nm, n_mrd, e_mrd); end
        checks++; if (n_mwr !== e_mwr) begin failures++; $display("FAIL %s mem_wr_cycles got=%0d exp=%0d", nm, n_mwr, e_mwr); end
        checks++; if (n_fd !== e_fd) begin failures++; $display("FAIL %s fill_dmem_pulses got=%0d exp=%0d", nm, n_fd, e_fd); end
        checks++; if (n_fdi !== e_fdi) begin failures++; $display("FAIL %s fill_datain_pulses got=%0d exp=%0d", nm, n_fdi, e_fdi); end
        checks++; if (n_bad !== 0) begin failures++; $display("FAIL %s mem_addr_errors got=%0d exp=0", nm, n_bad); end
        checks++; if (cr_ret !== e_cr) begin failures++; $display("FAIL %s cache_read_at_retire got=%b exp=%b", nm, cr_ret, e_cr); end
        checks++; if (hit_cnt !== 16'(e_hit)) begin failures++; $display("FAIL %s hit_cnt got=%0d exp=%0d", nm, hit_cnt, e_hit); end
        checks++; if (miss_cnt !== 16'(e_miss)) begin failures++; $display("FAIL %s miss_cnt got=%0d exp=%0d", nm, miss_cnt, e_miss); end
        checks++; if (hit_cnt2 !== 2'(e_hit2)) begin failures++; $display("FAIL %s hit_cnt_sat got=%0d exp=%0d", nm, hit_cnt2, e_hit2); end
        checks++; if (miss_cnt2 !== 2'(e_miss2)) begin failures++; $display("FAIL %s miss_cnt_sat got=%0d exp=%0d", nm, miss_cnt2, e_miss2); end
    endtask

    task automatic test_reset();
        rst = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; mem_ready = 1'b0;
        mvalid = '0;
        for (int i = 0; i < 32; i++) mtag[i] = 3'd0;
        mhits = 0; mmiss = 0;
        #12;
        checks++; if ({stall, cache_read, fill_from_Dmem, fill_from_DataIn, mem_rd, mem_wr} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=000000", {stall, cache_read, fill_from_Dmem, fill_from_DataIn, mem_rd, mem_wr}); end
        checks++; if (mem_addr !== 10'd0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=000", mem_addr); end
        checks++; if ({hit_cnt, miss_cnt} !== 32'd0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cold_read();
        do_op(1'b1, 1'b0, 10'h0A4, 3, "cold_read");
    endtask

    task automatic test_reread();
        do_op(1'b1, 1'b0, 10'h0A5, 1, "reread_hit");
        do_op(1'b0, 1'b0, 10'h0A5, 1, "no_request");
    endtask

    task automatic test_store_hit();
        do_op(1'b0, 1'b1, 10'h0A6, 1, "store_hit");
    endtask

    task automatic test_store_miss();
        do_op(1'b0, 1'b1, 10'h3A6, 2, "store_miss");
        do_op(1'b1, 1'b0, 10'h0A7, 1, "line_kept_after_store_miss");
    endtask

    task automatic test_rd_wr_both();
        do_op(1'b1, 1'b1, 10'h155, 2, "rd_wr_both");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, 10'h0A4, 1, "sat_hits");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [1:0] k = 2'($urandom_range(0, 3));
            // narrow tag range so lines get reused and both hits and misses occur
            logic [9:0] a = {3'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 2'($urandom)};
            do_op(k[0], k[1], a, int'($urandom_range(1, 4)), "random");
        end
    endtask

    task automatic test_reset_mid_rdwait();
        mvalid[5'h1C] = 1'b0;
        cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 10'h3F0; mem_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        #1;
        checks++; if (mem_rd !== 1'b1) begin failures++; $display("FAIL mid_rdwait_mem_rd got=%b exp=1", mem_rd); end
        #2 rst = 1'b0;
        #1 cpu_rd = 1'b0;
        #1;
        checks++; if ({stall, cache_read, fill_from_Dmem, fill_from_DataIn, mem_rd, mem_wr} !== 6'b0) begin
            failures++; $display("FAIL midreset_ctrl got=%b exp=000000", {stall, cache_read, fill_from_Dmem, fill_from_DataIn, mem_rd, mem_wr}); end
        checks++; if (mem_addr !== 10'd0) begin failures++; $display("FAIL midreset_mem_addr got=%h exp=000", mem_addr); end
        checks++; if ({hit_cnt, miss_cnt} !== 32'd0) begin failures++; $display("FAIL midreset_counters got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
        @(negedge clk); rst = 1'b1;
        mhits = 0; mmiss = 0;
        @(negedge clk);
        do_op(1'b1, 1'b0, 10'h3F0, 2, "post_reset_miss");
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_reread();
        test_store_hit();
        test_store_miss();
        test_rd_wr_both();
        test_saturation();
        test_random();
        test_reset_mid_rdwait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
